history_buffer_2tap: RTL and testbench

Per-bin two-tap block filter for the frequency-domain equalizer datapath. It receives one complex bin sample per valid cycle, in blocks of N bins. It keeps the previous block's N samples in an internal history memory and outputs Y[k] = W0·X_m[k] + W1·X_(m-1)[k] in the same Q format as the input. It sits after the FFT and before the error/adaptation stage, which supplies W0/W1.

---
 rtl/heq_pkg.sv | 32 +++
 rtl/cmul_q.sv | 39 +++
 rtl/history_buffer_2tap.sv | 130 +++++++++++++
 tb/tb_history_buffer_2tap.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/heq_pkg.sv
// Shared types, defaults and fixed-point helpers
// for the frequency-domain equalizer datapath.
package heq_pkg;

  localparam int W    = 16;
  localparam int FRAC = 14;
  localparam int N    = 32;
  localparam int KW   = $clog2(N);

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  // Round half up at bit frac, then clip to a signed w-bit range.
  function automatic logic signed [63:0] rnd_sat(
    input logic signed [63:0] s,
    input int                 frac,
    input int                 w
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (s + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/cmul_q.sv
// Registered complex multiplier; the four real partial
// products are kept at full precision for the adder.
module cmul_q #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [W-1:0]   a_re_i,
  input  logic signed [W-1:0]   a_im_i,
  input  logic signed [W-1:0]   b_re_i,
  input  logic signed [W-1:0]   b_im_i,
  output logic signed [2*W-1:0] rr_o,
  output logic signed [2*W-1:0] ii_o,
  output logic signed [2*W-1:0] ri_o,
  output logic signed [2*W-1:0] ir_o
);

  logic signed [2*W-1:0] rr_q, ii_q, ri_q, ir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else begin
      rr_q <= a_re_i * b_re_i;
      ii_q <= a_im_i * b_im_i;
      ri_q <= a_re_i * b_im_i;
      ir_q <= a_im_i * b_re_i;
    end
  end

  assign rr_o = rr_q;
  assign ii_o = ii_q;
  assign ri_o = ri_q;
  assign ir_o = ir_q;

endmodule

// File: rtl/history_buffer_2tap.sv
// Per-bin two-tap block filter: Y[k] = W0*X_m[k] + W1*X_(m-1)[k],
// two register stages, rounded and saturated back to input Q format.
module history_buffer_2tap #(
  parameter int W    = heq_pkg::W,
  parameter int FRAC = heq_pkg::FRAC,
  parameter int N    = heq_pkg::N,
  parameter int KW   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_X_re,
  input  logic signed [W-1:0] i_X_im,
  input  logic signed [W-1:0] i_W0_re,
  input  logic signed [W-1:0] i_W0_im,
  input  logic signed [W-1:0] i_W1_re,
  input  logic signed [W-1:0] i_W1_im,
  output logic                o_valid,
  output logic signed [W-1:0] o_Y_re,
  output logic signed [W-1:0] o_Y_im,
  output logic [KW-1:0]       o_k_idx
);

  import heq_pkg::*;

  localparam int SW = 2*W + 2;

  logic [KW-1:0]       k_q, k_d;
  logic signed [W-1:0] h_re_q [N];
  logic signed [W-1:0] h_im_q [N];
  logic signed [W-1:0] h_re, h_im;

  logic                v1_q;
  logic [KW-1:0]       k1_q;

  logic signed [2*W-1:0] p0_rr, p0_ii, p0_ri, p0_ir;
  logic signed [2*W-1:0] p1_rr, p1_ii, p1_ri, p1_ir;

  logic signed [SW-1:0] s_re_d, s_im_d;
  logic signed [W-1:0]  y_re_d, y_im_d;

  logic                v2_q;
  logic [KW-1:0]       k2_q;
  logic signed [W-1:0] y_re_q, y_im_q;

  // N is a power of two, so the counter wraps on its own.
  assign k_d  = k_q + 1'b1;
  assign h_re = h_re_q[k_q];
  assign h_im = h_im_q[k_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= '0;
      for (int i = 0; i < N; i++) begin
        h_re_q[i] <= '0;
        h_im_q[i] <= '0;
      end
    end else if (i_valid) begin
      k_q         <= k_d;
      h_re_q[k_q] <= i_X_re;
      h_im_q[k_q] <= i_X_im;
    end
  end

  cmul_q #(.W(W)) u_cmul0 (
    .clk    (clk),
    .rst    (rst),
    .a_re_i (i_W0_re),
    .a_im_i (i_W0_im),
    .b_re_i (i_X_re),
    .b_im_i (i_X_im),
    .rr_o   (p0_rr),
    .ii_o   (p0_ii),
    .ri_o   (p0_ri),
    .ir_o   (p0_ir)
  );

  cmul_q #(.W(W)) u_cmul1 (
    .clk    (clk),
    .rst    (rst),
    .a_re_i (i_W1_re),
    .a_im_i (i_W1_im),
    .b_re_i (h_re),
    .b_im_i (h_im),
    .rr_o   (p1_rr),
    .ii_o   (p1_ii),
    .ri_o   (p1_ri),
    .ir_o   (p1_ir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      k1_q <= '0;
    end else begin
      v1_q <= i_valid;
      k1_q <= k_q;
    end
  end

  assign s_re_d = SW'(p0_rr) - SW'(p0_ii)
                + SW'(p1_rr) - SW'(p1_ii);
  assign s_im_d = SW'(p0_ri) + SW'(p0_ir)
                + SW'(p1_ri) + SW'(p1_ir);

  assign y_re_d = W'(rnd_sat(64'(s_re_d), FRAC, W));
  assign y_im_d = W'(rnd_sat(64'(s_im_d), FRAC, W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      k2_q   <= '0;
      y_re_q <= '0;
      y_im_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        k2_q   <= k1_q;
        y_re_q <= y_re_d;
        y_im_q <= y_im_d;
      end
    end
  end

  assign o_valid = v2_q;
  assign o_k_idx = k2_q;
  assign o_Y_re  = y_re_q;
  assign o_Y_im  = y_im_q;

endmodule

// File: tb/tb_history_buffer_2tap.sv
// Directed bench for history_buffer_2tap with an
// expected-output queue timed against the cycle count.
module tb_history_buffer_2tap;

  localparam int U = 16384;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic signed [15:0] i_X_re = '0;
  logic signed [15:0] i_X_im = '0;
  logic signed [15:0] i_W0_re = '0;
  logic signed [15:0] i_W0_im = '0;
  logic signed [15:0] i_W1_re = '0;
  logic signed [15:0] i_W1_im = '0;
  logic               o_valid;
  logic signed [15:0] o_Y_re;
  logic signed [15:0] o_Y_im;
  logic [4:0]         o_k_idx;

  history_buffer_2tap dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_X_re  (i_X_re),
    .i_X_im  (i_X_im),
    .i_W0_re (i_W0_re),
    .i_W0_im (i_W0_im),
    .i_W1_re (i_W1_re),
    .i_W1_im (i_W1_im),
    .o_valid (o_valid),
    .o_Y_re  (o_Y_re),
    .o_Y_im  (o_Y_im),
    .o_k_idx (o_k_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    longint k;
    int     due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("latency", cyc, e.due);
          check("y_re", o_Y_re, e.re);
          check("y_im", o_Y_im, e.im);
          check("k_idx", o_k_idx, e.k);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        check("missing_valid", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input int xr, input int xi,
                      input int w0r, input int w0i,
                      input int w1r, input int w1i,
                      input int er, input int ei,
                      input int k);
    exp_t t;
    @(negedge clk);
    i_valid = 1'b1;
    i_X_re  = 16'(xr);
    i_X_im  = 16'(xi);
    i_W0_re = 16'(w0r);
    i_W0_im = 16'(w0i);
    i_W1_re = 16'(w1r);
    i_W1_im = 16'(w1i);
    t.re  = er;
    t.im  = ei;
    t.k   = k;
    t.due = cyc + 2;
    q.push_back(t);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    i_valid = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clk);
    check("drain", q.size(), 0);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_valid", o_valid, 0);
    check("rst_y_re", o_Y_re, 0);
    check("rst_y_im", o_Y_im, 0);
    check("rst_k", o_k_idx, 0);

    // unit-gain carry across blocks, with a gap
    for (int k = 0; k < 32; k++)
      send(1000, 0, U, 0, U, 0, 1000, 0, k);
    idle(3);
    for (int k = 0; k < 32; k++)
      send(2000, 0, U, 0, U, 0, 3000, 0, k);
    idle(1);
    drain();

    // index run with X = k, then wrap to bin 0
    do_reset();
    for (int k = 0; k < 32; k++)
      send(k, 0, U, 0, U, 0, k, 0, k);
    send(5, 0, U, 0, U, 0, 5, 0, 0);
    idle(1);
    drain();

    // rotation by j, then rounding boundaries
    do_reset();
    for (int k = 0; k < 4; k++)
      send(1000, 500, 0, U, 0, 0, -500, 1000, k);
    send(8192, 0, 1, 0, 0, 0, 1, 0, 4);
    send(-8192, 0, 1, 0, 0, 0, 0, 0, 5);
    send(8191, 0, 1, 0, 0, 0, 0, 0, 6);
    send(-8193, 0, 1, 0, 0, 0, -1, 0, 7);
    idle(1);
    drain();

    // saturation, both blocks
    do_reset();
    for (int k = 0; k < 64; k++)
      send(32767, -32768, 32767, 0, 32767, 0,
           32767, -32768, k % 32);
    idle(1);
    drain();

    // reset mid-block discards history and in-flight data
    do_reset();
    for (int k = 0; k < 32; k++)
      send(1000, 0, U, 0, U, 0, 1000, 0, k);
    for (int k = 0; k < 10; k++)
      send(1000, 0, U, 0, U, 0, 2000, 0, k);
    do_reset();
    for (int k = 0; k < 32; k++)
      send(2000, 0, U, 0, U, 0, 2000, 0, k);
    idle(1);
    drain();

    // gapped input over two blocks
    do_reset();
    for (int k = 0; k < 32; k++) begin
      send(10*k, -k, U, 0, U, 0, 10*k, -k, k);
      idle(1);
    end
    for (int k = 0; k < 32; k++) begin
      send(20*k, k, U, 0, U, 0, 30*k, 0, k);
      idle(1);
    end
    idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
